// File: rtl/x_mux_pkg.sv
// Shared types and constants for the scanning channel selector.
package x_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAN,
      ST_SCAN
   } state_t;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/x_prio_next.sv
// Rotating priority encoder: first set mask bit after cur, wrapping through 0..cur.
// With cur = N-1 it returns the lowest set bit.
module x_prio_next #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] cur,
   output logic [IDX_W-1:0] next,
   output logic             found,
   output logic             wrapped
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      next    = '0;
      found   = 1'b0;
      wrapped = 1'b0;
      cand    = '0;
      for (int off = 1; off <= N; off++) begin
         cand = IDX_W'((int'(cur) + off) % N);
         if (!found && mask[cand]) begin
            found   = 1'b1;
            next    = cand;
            wrapped = (int'(cur) + off) >= N;
         end
      end
   end

endmodule

// File: rtl/x_mux_scan.sv
// N-channel selector with manual hold or round-robin scan, registered output
// and valid/ready handshake towards a single consumer.
module x_mux_scan
   import x_mux_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int W     = 1,
   parameter  int DWELL = 1,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N*W-1:0]   i_data,
   input  logic [N-1:0]     i_mask,
   input  logic             i_mode,
   input  logic [IDX_W-1:0] i_sel,
   input  logic             i_sel_load,
   output logic [W-1:0]     o_y,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_wrap
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   state_t           state;
   logic [IDX_W-1:0] sel_q;
   logic [IDX_W-1:0] cur;
   logic [DW_W-1:0]  dwell;
   logic             wrap_pend;
   logic             cap;

   logic [W-1:0]     ch [N];
   logic [IDX_W-1:0] nxt_idx;
   logic             nxt_found;
   logic             nxt_wrap;
   logic [IDX_W-1:0] low_idx;
   logic             low_found;
   logic             low_wrap_unused;
   logic [IDX_W-1:0] scan_entry;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         ch[k] = i_data[k*W +: W];
      end
   end

   x_prio_next #(.N(N), .IDX_W(IDX_W)) u_next (
      .mask    (i_mask),
      .cur     (cur),
      .next    (nxt_idx),
      .found   (nxt_found),
      .wrapped (nxt_wrap)
   );

   x_prio_next #(.N(N), .IDX_W(IDX_W)) u_low (
      .mask    (i_mask),
      .cur     (IDX_W'(N - 1)),
      .next    (low_idx),
      .found   (low_found),
      .wrapped (low_wrap_unused)
   );

   assign scan_entry = low_found ? low_idx : '0;
   assign cap        = !o_valid || i_ready;

   // Manual index loads even while the output is stalled; out-of-range indices are dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sel_q <= '0;
      end else if (i_sel_load && (int'(i_sel) < N)) begin
         sel_q <= i_sel;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         cur       <= '0;
         dwell     <= '0;
         wrap_pend <= 1'b0;
         o_y       <= '0;
         o_idx     <= '0;
         o_valid   <= 1'b0;
         o_wrap    <= 1'b0;
      end else if (cap) begin
         case (state)
            ST_IDLE: begin
               o_valid <= 1'b0;
               o_wrap  <= 1'b0;
               if (i_mode == MODE_MAN) begin
                  state <= ST_MAN;
               end else begin
                  state     <= ST_SCAN;
                  cur       <= scan_entry;
                  dwell     <= '0;
                  wrap_pend <= 1'b0;
               end
            end
            ST_MAN: begin
               o_wrap <= 1'b0;
               if (i_mode != MODE_MAN) begin
                  state     <= ST_SCAN;
                  cur       <= scan_entry;
                  dwell     <= '0;
                  wrap_pend <= 1'b0;
                  o_valid   <= 1'b0;
               end else if (i_mask[sel_q]) begin
                  o_y     <= ch[sel_q];
                  o_idx   <= sel_q;
                  o_valid <= 1'b1;
               end else begin
                  o_valid <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (i_mode != MODE_SCAN) begin
                  state   <= ST_MAN;
                  o_valid <= 1'b0;
                  o_wrap  <= 1'b0;
               end else if (!i_mask[cur]) begin
                  // Current channel disabled: spend one bubble hopping to the next live one.
                  o_valid <= 1'b0;
                  o_wrap  <= 1'b0;
                  dwell   <= '0;
                  if (nxt_found) begin
                     cur <= nxt_idx;
                  end
               end else begin
                  o_y       <= ch[cur];
                  o_idx     <= cur;
                  o_valid   <= 1'b1;
                  o_wrap    <= wrap_pend;
                  wrap_pend <= 1'b0;
                  if (dwell == DW_W'(DWELL - 1)) begin
                     cur       <= nxt_idx;
                     dwell     <= '0;
                     wrap_pend <= nxt_wrap;
                  end else begin
                     dwell <= dwell + 1'b1;
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               o_valid <= 1'b0;
               o_wrap  <= 1'b0;
            end
         endcase
      end
   end

endmodule
